// File: rtl/fsm_share_sched.sv
// Time-shared 4-state Moore detector serving 4 serial channels, round-robin arbitrated.
// Latency: result 1 cycle after grant. Backpressure: one-hot ch_ready, a requester holds bit until granted.
module fsm_share_sched #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       ch_valid,
    input  logic [3:0]       ch_bit,
    output logic [3:0]       ch_ready,
    input  logic [3:0]       ch_flush,
    output logic             res_valid,
    output logic [1:0]       res_ch,
    output logic             res_match,
    input  logic [1:0]       cnt_sel,
    output logic [CNT_W-1:0] cnt_val
);

    typedef enum logic [1:0] {
        ST_A = 2'd0,
        ST_B = 2'd1,
        ST_C = 2'd2,
        ST_D = 2'd3
    } det_state_t;

    typedef struct packed {
        logic       vld;
        logic [1:0] ch;
        logic       match;
    } res_t;

    det_state_t       st_q  [4];
    det_state_t       st_d  [4];
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];
    logic [1:0]       ptr_q;
    logic [1:0]       ptr_d;
    res_t             res_q;
    res_t             res_d;

    logic             gnt_vld;
    logic [1:0]       gnt_ch;
    logic [1:0]       cand;
    logic             grant;
    det_state_t       det_base;
    det_state_t       det_nxt;

    function automatic det_state_t det_next(input det_state_t s, input logic b);
        det_state_t n;
        case (s)
            ST_A:    n = b ? ST_B : ST_A;
            ST_B:    n = b ? ST_B : ST_C;
            ST_C:    n = b ? ST_D : ST_A;
            default: n = b ? ST_B : ST_C;
        endcase
        return n;
    endfunction

    // Round-robin search from ptr upward; first requester wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_ch  = ptr_q;
        cand    = 2'd0;
        for (int i = 0; i < 4; i++) begin
            cand = ptr_q + 2'(i);
            if (!gnt_vld && ch_valid[cand]) begin
                gnt_vld = 1'b1;
                gnt_ch  = cand;
            end
        end
    end

    assign grant    = gnt_vld & ~reset;
    assign ch_ready = grant ? (4'b0001 << gnt_ch) : 4'b0000;

    // A flush colliding with a grant makes the detector start from A.
    always_comb begin
        det_base = ch_flush[gnt_ch] ? ST_A : st_q[gnt_ch];
        det_nxt  = det_next(det_base, ch_bit[gnt_ch]);
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            st_d[i]  = ch_flush[i] ? ST_A : st_q[i];
            cnt_d[i] = cnt_q[i];
        end
        ptr_d = ptr_q;
        res_d = '0;
        if (grant) begin
            st_d[gnt_ch] = det_nxt;
            ptr_d        = gnt_ch + 2'd1;
            res_d.vld    = 1'b1;
            res_d.ch     = gnt_ch;
            res_d.match  = (det_nxt == ST_D);
            if (det_nxt == ST_D && cnt_q[gnt_ch] != {CNT_W{1'b1}}) begin
                cnt_d[gnt_ch] = cnt_q[gnt_ch] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                st_q[i]  <= ST_A;
                cnt_q[i] <= '0;
            end
            ptr_q <= 2'd0;
            res_q <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                st_q[i]  <= st_d[i];
                cnt_q[i] <= cnt_d[i];
            end
            ptr_q <= ptr_d;
            res_q <= res_d;
        end
    end

    assign res_valid = res_q.vld;
    assign res_ch    = res_q.ch;
    assign res_match = res_q.match;
    assign cnt_val   = cnt_q[cnt_sel];

endmodule

// File: tb/tb_fsm_share_sched.sv
// Scoreboarded random and directed bench for fsm_share_sched against a table-driven model.
module tb_fsm_share_sched;
    localparam int CNT_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [3:0]       ch_valid = '0;
    logic [3:0]       ch_bit = '0;
    logic [3:0]       ch_ready;
    logic [3:0]       ch_flush = '0;
    logic             res_valid;
    logic [1:0]       res_ch;
    logic             res_match;
    logic [1:0]       cnt_sel = '0;
    logic [CNT_W-1:0] cnt_val;

    fsm_share_sched #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .ch_valid(ch_valid), .ch_bit(ch_bit),
        .ch_ready(ch_ready), .ch_flush(ch_flush), .res_valid(res_valid),
        .res_ch(res_ch), .res_match(res_match), .cnt_sel(cnt_sel), .cnt_val(cnt_val)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: detector transition table indexed [state][bit]
    int next_tab [4][2] = '{'{0, 1}, '{2, 1}, '{0, 3}, '{2, 1}};
    int m_state [4];
    int m_cnt   [4];
    int m_ptr;

    typedef struct {
        int cyc;
        int ch;
        bit match;
    } exp_t;
    exp_t sb[$];

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_state[i] = 0;
            m_cnt[i]   = 0;
        end
        m_ptr = 0;
    endtask

    // One clock cycle of stimulus; returns the channel granted (-1 for none).
    task automatic step(input logic [3:0] v, input logic [3:0] b, input logic [3:0] f,
                        input logic r, input logic [1:0] sel, output int g);
        logic [3:0] exp_rdy;
        int s;
        int ns;
        @(posedge clk);
        #1;
        ch_valid = v; ch_bit = b; ch_flush = f; reset = r; cnt_sel = sel;
        #2;
        g = -1;
        if (!r) begin
            for (int i = 0; i < 4; i++) begin
                if (g < 0 && v[(m_ptr + i) % 4]) g = (m_ptr + i) % 4;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("ch_ready", 32'(ch_ready), 32'(exp_rdy));
        chk("cnt_val", 32'(cnt_val), 32'(m_cnt[sel]));
        if (r) begin
            model_reset();
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (f[i] && i != g) m_state[i] = 0;
            end
            if (g >= 0) begin
                s  = f[g] ? 0 : m_state[g];
                ns = next_tab[s][b[g]];
                m_state[g] = ns;
                if (ns == 3 && m_cnt[g] < CMAX) m_cnt[g]++;
                sb.push_back('{cyc: cyc, ch: g, match: (ns == 3)});
                m_ptr = (g + 1) % 4;
            end
        end
    endtask

    // Monitor: pops an expectation whenever the DUT presents a result
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (res_valid === 1'b1) begin
                if (sb.size() == 0 || sb[0].cyc >= cyc) begin
                    chk("spurious_res", 32'(res_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("res_latency", 32'(cyc - e.cyc), 32'd1);
                    chk("res_ch", 32'(res_ch), 32'(e.ch));
                    chk("res_match", 32'(res_match), 32'(e.match));
                end
            end else begin
                chk("idle_res", {30'd0, res_ch, res_match}, 32'd0);
                if (sb.size() > 0 && sb[0].cyc < cyc) begin
                    e = sb.pop_front();
                    chk("missing_res", 32'(res_valid), 32'd1);
                end
            end
        end
    end

    initial begin
        int g;
        logic [3:0] pend;
        logic [3:0] pbit;
        logic [3:0] fl;
        logic [3:0] bits;
        logic [3:0] seq1;
        model_reset();

        step(4'h0, 4'h0, 4'h0, 1'b1, 2'd0, g);
        step(4'h0, 4'h0, 4'h0, 1'b1, 2'd0, g);
        for (int i = 0; i < 4; i++) begin
            step(4'h0, 4'h0, 4'h0, 1'b0, 2'(i), g);
            chk("reset_cnt", 32'(cnt_val), 32'd0);
        end

        // Single channel 1,0,1 -> one match
        step(4'b0001, 4'b0001, 4'h0, 1'b0, 2'd0, g);
        step(4'b0001, 4'b0000, 4'h0, 1'b0, 2'd0, g);
        step(4'b0001, 4'b0001, 4'h0, 1'b0, 2'd0, g);
        step(4'h0, 4'h0, 4'h0, 1'b0, 2'd0, g);
        chk("single_cnt0", 32'(cnt_val), 32'd1);

        // Fairness with all channels requesting
        step(4'h0, 4'h0, 4'h0, 1'b1, 2'd0, g);
        for (int i = 0; i < 8; i++) begin
            step(4'b1111, 4'h0, 4'h0, 1'b0, 2'd0, g);
            chk("fair_gnt", 32'(ch_ready), 32'(4'b0001 << (i % 4)));
        end

        // Interleaved ch1 (1,0,1) and ch2 (0,0,0)
        step(4'h0, 4'h0, 4'h0, 1'b1, 2'd0, g);
        seq1 = 4'b0101;
        for (int i = 0; i < 6; i++) begin
            bits = {2'b00, seq1[i / 2], 1'b0};
            step(4'b0110, bits, 4'h0, 1'b0, 2'd2, g);
        end
        step(4'h0, 4'h0, 4'h0, 1'b0, 2'd2, g);
        chk("interleave_cnt2", 32'(cnt_val), 32'd0);
        step(4'h0, 4'h0, 4'h0, 1'b0, 2'd1, g);
        chk("interleave_cnt1", 32'(cnt_val), 32'd1);

        // Flush colliding with a grant while ch0 sits in C
        step(4'h0, 4'h0, 4'h0, 1'b1, 2'd0, g);
        step(4'b0001, 4'b0001, 4'h0, 1'b0, 2'd0, g);
        step(4'b0001, 4'b0000, 4'h0, 1'b0, 2'd0, g);
        step(4'b0001, 4'b0001, 4'b0001, 1'b0, 2'd0, g);
        step(4'b0001, 4'b0000, 4'h0, 1'b0, 2'd0, g);
        chk("flush_cnt0", 32'(cnt_val), 32'd0);
        step(4'b0001, 4'b0001, 4'h0, 1'b0, 2'd0, g);
        step(4'h0, 4'h0, 4'h0, 1'b0, 2'd0, g);
        chk("flush_then_match", 32'(cnt_val), 32'd1);

        // Saturation: five matches on a 2-bit counter
        step(4'h0, 4'h0, 4'h0, 1'b1, 2'd0, g);
        for (int i = 0; i < 11; i++) begin
            step(4'b0001, {3'b000, ~i[0]}, 4'h0, 1'b0, 2'd0, g);
        end
        step(4'h0, 4'h0, 4'h0, 1'b0, 2'd0, g);
        chk("sat_cnt0", 32'(cnt_val), 32'd3);

        // Reset in the middle of traffic
        for (int i = 0; i < 5; i++) step(4'b1111, 4'b1111, 4'h0, 1'b0, 2'd1, g);
        step(4'b1010, 4'b1010, 4'h0, 1'b1, 2'd1, g);
        step(4'b1010, 4'b1010, 4'h0, 1'b0, 2'd1, g);
        chk("post_rst_gnt", 32'(ch_ready), 32'(4'b0010));
        chk("post_rst_cnt", 32'(cnt_val), 32'd0);

        // Random traffic; requesters hold their bit until granted
        pend = '0;
        pbit = '0;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 4; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    pbit[i] = 1'($urandom_range(0, 1));
                end
                fl[i] = ($urandom_range(0, 7) == 0);
            end
            step(pend, pbit, fl, ($urandom_range(0, 199) == 0), 2'($urandom_range(0, 3)), g);
            if (g >= 0) pend[g] = 1'b0;
        end

        step(4'h0, 4'h0, 4'h0, 1'b0, 2'd0, g);
        step(4'h0, 4'h0, 4'h0, 1'b0, 2'd0, g);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
